// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-master OBI memory arbiter.
// Master ids, master count and the round-robin pick helper live here.
package obi_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef logic mst_id_t;

  localparam mst_id_t MST_INSTR = 1'b0;
  localparam mst_id_t MST_DATA  = 1'b1;

  // A sole requester wins; on a tie, or with nobody requesting, the master
  // that did not win last time is picked.
  function automatic mst_id_t rr_select(input logic [NUM_MASTERS-1:0] req,
                                        input mst_id_t last);
    if (req == 2'b01) return MST_INSTR;
    if (req == 2'b10) return MST_DATA;
    return mst_id_t'(~last);
  endfunction

endpackage

// File: rtl/cv32e_obi_mem_arbiter_if.sv
// One OBI channel (request + response) with master and slave views.
// Bundles the per-master and slave-side signals around the arbiter.
interface cv32e_obi_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
) ();

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/obi_id_fifo.sv
// In-order FIFO of granted master ids, one entry per outstanding transaction.
// Push and pop may happen together; pointers wrap modulo DEPTH.
module obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset; an entry is only read after it was written,
  // since the count gates every pop.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cv32e_obi_mem_arbiter.sv
// Round-robin arbiter merging the instruction-side and data OBI masters onto
// one slave port, routing responses back in order through an id FIFO.
module cv32e_obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_MASTERS-1:0]                  m_req_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0]                  m_we_i,
  input  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]    m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  output logic [NUM_MASTERS-1:0]                  m_gnt_o,
  output logic [NUM_MASTERS-1:0]                  m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                   m_rdata_o,
  output logic                                    s_req_o,
  output logic [ADDR_WIDTH-1:0]                   s_addr_o,
  output logic                                    s_we_o,
  output logic [BE_WIDTH-1:0]                     s_be_o,
  output logic [DATA_WIDTH-1:0]                   s_wdata_o,
  input  logic                                    s_gnt_i,
  input  logic                                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                   s_rdata_i
);

  logic    r_locked;
  mst_id_t r_lock_id;
  mst_id_t r_last;
  mst_id_t w_sel;
  mst_id_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_s_req;
  logic    w_handshake;
  logic    w_pop;

  // A request left waiting for grant keeps its master selected.
  assign w_sel       = r_locked ? r_lock_id : rr_select(m_req_i, r_last);
  assign w_s_req     = rst_ni & m_req_i[w_sel] & ~w_full;
  assign w_handshake = w_s_req & s_gnt_i;
  assign w_pop       = s_rvalid_i & ~w_empty;

  assign s_req_o   = w_s_req;
  assign s_addr_o  = m_addr_i[w_sel];
  assign s_we_o    = m_we_i[w_sel];
  assign s_be_o    = m_be_i[w_sel];
  assign s_wdata_o = m_wdata_i[w_sel];
  assign m_rdata_o = s_rdata_i;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a bit unassigned and no latch is inferred.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (w_handshake) m_gnt_o[w_sel]     = 1'b1;
    if (w_pop)       m_rvalid_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked  <= 1'b0;
      r_lock_id <= MST_INSTR;
      r_last    <= MST_DATA;
    end else begin
      r_locked  <= w_s_req & ~s_gnt_i;
      r_lock_id <= w_sel;
      if (w_handshake) r_last <= w_sel;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(mst_id_t))
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_handshake),
    .i_pop   (w_pop),
    .i_data  (w_sel),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && s_rvalid_i)
      assert (!w_empty) else $warning("s_rvalid_i with no outstanding transaction ignored");
  end
`endif

endmodule
